// File: rtl/scalar_mult_ctrl.sv
// ----------------------------------------------------------------------------
// scalar_mult_ctrl
//   Double-and-add sequencer that computes k*P on Ed25519 by driving an
//   external PointAdd engine. Scans the scalar MSB-first, issues one
//   initial-conversion transaction, then a doubling per remaining bit and an
//   addition per set bit. No field arithmetic happens here.
//
//   Optional feature macro: SCALAR_MULT_CONST_TIME_EN
//     defined   : scan always takes SCALAR_W cycles, an addition follows every
//                 doubling and is committed only when the scalar bit is set.
//     undefined : variable-time double-and-add.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start                    start pulse (ignored while busy)
//   i_scalar                   scalar k
//   i_px, i_py                 affine base point
//   o_busy, o_done, o_inf      status; o_inf flags the identity result (k==0)
//   o_x, o_y, o_z, o_t         result accumulator (extended coordinates)
//   o_pa_start                 PointAdd start pulse
//   o_pa_doubling, o_pa_initial PointAdd operation select
//   o_pa_{x,y,z,t}1            PointAdd operand 1 (accumulator)
//   o_pa_{x,y,z,t}2            PointAdd operand 2 (base point B)
//   i_pa_{x,y,z,t}3            PointAdd result, valid with i_pa_finished
//   i_pa_finished              PointAdd completion pulse
// ----------------------------------------------------------------------------
module scalar_mult_ctrl #(
  parameter int unsigned SCALAR_W = 255,
  parameter int unsigned COORD_W  = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [SCALAR_W-1:0] i_scalar,
  input  logic [COORD_W-1:0]  i_px,
  input  logic [COORD_W-1:0]  i_py,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_inf,
  output logic [COORD_W-1:0]  o_x,
  output logic [COORD_W-1:0]  o_y,
  output logic [COORD_W-1:0]  o_z,
  output logic [COORD_W-1:0]  o_t,
  output logic                o_pa_start,
  output logic                o_pa_doubling,
  output logic                o_pa_initial,
  output logic [COORD_W-1:0]  o_pa_x1,
  output logic [COORD_W-1:0]  o_pa_y1,
  output logic [COORD_W-1:0]  o_pa_z1,
  output logic [COORD_W-1:0]  o_pa_t1,
  output logic [COORD_W-1:0]  o_pa_x2,
  output logic [COORD_W-1:0]  o_pa_y2,
  output logic [COORD_W-1:0]  o_pa_z2,
  output logic [COORD_W-1:0]  o_pa_t2,
  input  logic [COORD_W-1:0]  i_pa_x3,
  input  logic [COORD_W-1:0]  i_pa_y3,
  input  logic [COORD_W-1:0]  i_pa_z3,
  input  logic [COORD_W-1:0]  i_pa_t3,
  input  logic                i_pa_finished
);

  localparam int unsigned IDX_W = (SCALAR_W > 1) ? $clog2(SCALAR_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SCALAR_W - 1);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] t;
  } point_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_INIT,
    S_WAIT_INIT,
    S_DBL,
    S_WAIT_DBL,
    S_ADD,
    S_WAIT_ADD,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [SCALAR_W-1:0]   k_q;
  logic [COORD_W-1:0]    px_q;
  logic [COORD_W-1:0]    py_q;
  logic [IDX_W-1:0]      idx_q;
  point_t                acc_q;
  point_t                b_q;
  point_t                op1_q;
  point_t                op2_q;
  point_t                pa_res;
`ifdef SCALAR_MULT_CONST_TIME_EN
  logic [IDX_W-1:0]      scan_q;
  logic                  found_q;
`endif

  assign pa_res = {i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3};

  assign o_x     = acc_q.x;
  assign o_y     = acc_q.y;
  assign o_z     = acc_q.z;
  assign o_t     = acc_q.t;
  assign o_pa_x1 = op1_q.x;
  assign o_pa_y1 = op1_q.y;
  assign o_pa_z1 = op1_q.z;
  assign o_pa_t1 = op1_q.t;
  assign o_pa_x2 = op2_q.x;
  assign o_pa_y2 = op2_q.y;
  assign o_pa_z2 = op2_q.z;
  assign o_pa_t2 = op2_q.t;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      px_q          <= '0;
      py_q          <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      b_q           <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_inf         <= 1'b0;
      o_pa_start    <= 1'b0;
      o_pa_doubling <= 1'b0;
      o_pa_initial  <= 1'b0;
`ifdef SCALAR_MULT_CONST_TIME_EN
      scan_q        <= '0;
      found_q       <= 1'b0;
`endif
    end else begin
      // Both are single-cycle pulses.
      o_done     <= 1'b0;
      o_pa_start <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            k_q    <= i_scalar;
            px_q   <= i_px;
            py_q   <= i_py;
            idx_q  <= IDX_MAX;
            acc_q  <= '0;
            o_busy <= 1'b1;
`ifdef SCALAR_MULT_CONST_TIME_EN
            scan_q  <= IDX_MAX;
            found_q <= 1'b0;
`endif
            if (i_scalar == '0) begin
              // Identity result: no PointAdd traffic at all.
              o_inf   <= 1'b1;
              o_done  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              o_inf   <= 1'b0;
              state_q <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          // Latch the MSB position on first hit but keep counting to the end.
          if (!found_q && k_q[scan_q]) begin
            idx_q   <= scan_q;
            found_q <= 1'b1;
          end
          if (scan_q == '0) begin
            state_q <= S_INIT;
          end else begin
            scan_q <= scan_q - 1'b1;
          end
`else
          if (k_q[idx_q]) begin
            state_q <= S_INIT;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
`endif
        end

        S_INIT: begin
          o_pa_start    <= 1'b1;
          o_pa_initial  <= 1'b1;
          o_pa_doubling <= 1'b0;
          op1_q         <= '{x: px_q, y: py_q, z: '0, t: '0};
          op2_q         <= '0;
          state_q       <= S_WAIT_INIT;
        end

        S_WAIT_INIT: begin
          if (i_pa_finished) begin
            // The converted point is both the base B and the starting accumulator.
            b_q   <= pa_res;
            acc_q <= pa_res;
            if (idx_q == '0) begin
              o_done  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= S_DBL;
            end
          end
        end

        S_DBL: begin
          o_pa_start    <= 1'b1;
          o_pa_initial  <= 1'b0;
          o_pa_doubling <= 1'b1;
          op1_q         <= acc_q;
          op2_q         <= b_q;
          state_q       <= S_WAIT_DBL;
        end

        S_WAIT_DBL: begin
          if (i_pa_finished) begin
            acc_q <= pa_res;
`ifdef SCALAR_MULT_CONST_TIME_EN
            state_q <= S_ADD;
`else
            if (k_q[idx_q]) begin
              state_q <= S_ADD;
            end else if (idx_q == '0) begin
              o_done  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= S_DBL;
            end
`endif
          end
        end

        S_ADD: begin
          o_pa_start    <= 1'b1;
          o_pa_initial  <= 1'b0;
          o_pa_doubling <= 1'b0;
          op1_q         <= acc_q;
          op2_q         <= b_q;
          state_q       <= S_WAIT_ADD;
        end

        S_WAIT_ADD: begin
          if (i_pa_finished) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
            // Dummy additions for clear bits are computed and thrown away.
            if (k_q[idx_q]) begin
              acc_q <= pa_res;
            end
`else
            acc_q <= pa_res;
`endif
            if (idx_q == '0) begin
              o_done  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= S_DBL;
            end
          end
        end

        S_DONE: begin
          o_busy  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
module tb_scalar_mult_ctrl;

  localparam int unsigned SW = 255;
  localparam int unsigned CW = 255;
  localparam int TIMEOUT = 5000;

  // Operation code as {o_pa_initial, o_pa_doubling}.
  localparam logic [1:0] OP_INIT = 2'b10;
  localparam logic [1:0] OP_DBL  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b00;

  typedef struct {
    logic          inf;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] z;
    logic [CW-1:0] t;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] scalar = '0;
  logic [CW-1:0] px = '0;
  logic [CW-1:0] py = '0;
  logic          busy, done, inf;
  logic [CW-1:0] x, y, z, t;
  logic          pa_start, pa_dbl, pa_init;
  logic [CW-1:0] x1, y1, z1, t1, x2, y2, z2, t2;
  logic [CW-1:0] x3, y3, z3, t3;
  logic          pa_fin;

  int n_checks = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_pa_start = 0;
  int busy_drop = 0;
  bit busy_watch = 1'b0;

  logic [1:0] exp_ops[$];
  res_t       exp_res[$];

  always #5 clk = ~clk;

  scalar_mult_ctrl #(.SCALAR_W(SW), .COORD_W(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_scalar      (scalar),
    .i_px          (px),
    .i_py          (py),
    .o_busy        (busy),
    .o_done        (done),
    .o_inf         (inf),
    .o_x           (x),
    .o_y           (y),
    .o_z           (z),
    .o_t           (t),
    .o_pa_start    (pa_start),
    .o_pa_doubling (pa_dbl),
    .o_pa_initial  (pa_init),
    .o_pa_x1       (x1),
    .o_pa_y1       (y1),
    .o_pa_z1       (z1),
    .o_pa_t1       (t1),
    .o_pa_x2       (x2),
    .o_pa_y2       (y2),
    .o_pa_z2       (z2),
    .o_pa_t2       (t2),
    .i_pa_x3       (x3),
    .i_pa_y3       (y3),
    .i_pa_z3       (z3),
    .i_pa_t3       (t3),
    .i_pa_finished (pa_fin)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // PointAdd stand-in: fixed 4-cycle latency; init=(x1,y1,1,x1^y1), dbl=2*op1, add=op1+op2.
  int            pa_cnt;
  logic [1:0]    pa_op;
  logic [CW-1:0] la[4];
  logic [CW-1:0] lb[4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_cnt <= 0;
      pa_fin <= 1'b0;
      x3 <= '0; y3 <= '0; z3 <= '0; t3 <= '0;
    end else begin
      pa_fin <= 1'b0;
      if (pa_start) begin
        pa_cnt <= 4;
        pa_op  <= {pa_init, pa_dbl};
        la[0] <= x1; la[1] <= y1; la[2] <= z1; la[3] <= t1;
        lb[0] <= x2; lb[1] <= y2; lb[2] <= z2; lb[3] <= t2;
      end else if (pa_cnt != 0) begin
        pa_cnt <= pa_cnt - 1;
        if (pa_cnt == 1) begin
          pa_fin <= 1'b1;
          if (pa_op == OP_INIT) begin
            x3 <= la[0]; y3 <= la[1]; z3 <= CW'(1); t3 <= la[0] ^ la[1];
          end else if (pa_op == OP_DBL) begin
            x3 <= la[0] << 1; y3 <= la[1] << 1; z3 <= la[2] << 1; t3 <= la[3] << 1;
          end else begin
            x3 <= la[0] + lb[0]; y3 <= la[1] + lb[1];
            z3 <= la[2] + lb[2]; t3 <= la[3] + lb[3];
          end
        end
      end
    end
  end

  // Scoreboard side: compare issued ops and completed results against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pa_start) begin
        n_pa_start++;
        if (exp_ops.size() == 0) check_eq("op_extra", exp_ops.size(), 1);
        else check_eq("op_kind", {pa_init, pa_dbl}, exp_ops.pop_front());
      end
      if (done) begin
        res_t r;
        n_done++;
        if (exp_res.size() == 0) begin
          check_eq("done_extra", exp_res.size(), 1);
        end else begin
          r = exp_res.pop_front();
          check_eq("res_inf", inf, r.inf);
          check_eq("res_x", x, r.x);
          check_eq("res_y", y, r.y);
          check_eq("res_z", z, r.z);
          check_eq("res_t", t, r.t);
        end
      end
      if (busy_watch && !busy) busy_drop++;
    end
  end

  task automatic push_expect(input logic [SW-1:0] k, input logic [CW-1:0] ax, input logic [CW-1:0] ay);
    res_t r;
    int msb = -1;
    logic [CW-1:0] kc = CW'(k);
    r.inf = (k == '0);
    r.x = kc * ax;
    r.y = kc * ay;
    r.z = kc;
    r.t = kc * (ax ^ ay);
    exp_res.push_back(r);
    for (int i = 0; i < int'(SW); i++) if (k[i]) msb = i;
    if (msb >= 0) begin
      exp_ops.push_back(OP_INIT);
      for (int i = msb - 1; i >= 0; i--) begin
        exp_ops.push_back(OP_DBL);
`ifdef SCALAR_MULT_CONST_TIME_EN
        exp_ops.push_back(OP_ADD);
`else
        if (k[i]) exp_ops.push_back(OP_ADD);
`endif
      end
    end
  endtask

  // Runs one scalar multiplication; cycles counts from acceptance to o_done.
  task automatic run_k(input logic [SW-1:0] k, input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                       input bit poke, output int cycles);
    int base = n_done;
    push_expect(k, ax, ay);
    @(negedge clk);
    scalar = k; px = ax; py = ay; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    busy_watch = 1'b1;
    cycles = 1;
    while (n_done == base && cycles < TIMEOUT) begin
      if (poke && cycles == 20) begin
        start = 1'b1; scalar = SW'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    busy_watch = 1'b0;
    check_eq("done_seen", n_done - base, 1);
  endtask

  initial begin
    int cyc, cyc4, cyc7, pa0, d0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_x", x, 0);
    check_eq("rst_pa_start", pa_start, 0);
    check_eq("rst_pa_x1", x1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_inf", inf, 0);

    // k=1: one init transaction only.
    pa0 = n_pa_start;
    run_k(SW'(1), CW'(9), CW'(4), 1'b0, cyc);
    check_eq("k1_pa_count", n_pa_start - pa0, 1);

    // k=0: early identity result, no PointAdd traffic.
    pa0 = n_pa_start;
    run_k('0, CW'(9), CW'(4), 1'b0, cyc);
    check_eq("k0_latency_le2", cyc <= 2, 1);
    check_eq("k0_pa_count", n_pa_start - pa0, 0);

    // k=5 with a start pulse injected mid-run that must be ignored.
    pa0 = n_pa_start;
    d0 = n_done;
    run_k(SW'(5), CW'(7), CW'(3), 1'b1, cyc);
    repeat (40) @(negedge clk);
    #1;
    check_eq("k5_single_done", n_done - d0, 1);
`ifdef SCALAR_MULT_CONST_TIME_EN
    check_eq("k5_pa_count", n_pa_start - pa0, 5);
`else
    check_eq("k5_pa_count", n_pa_start - pa0, 4);
`endif

    // k=2^254: long doubling chain.
    pa0 = n_pa_start;
    d0 = n_done;
    busy_drop = 0;
    run_k(SW'(1) << 254, CW'(11), CW'(6), 1'b0, cyc);
    repeat (10) @(negedge clk);
    #1;
    check_eq("k254_busy_hold", busy_drop, 0);
    check_eq("k254_done_once", n_done - d0, 1);
`ifdef SCALAR_MULT_CONST_TIME_EN
    check_eq("k254_pa_count", n_pa_start - pa0, 509);
`else
    check_eq("k254_pa_count", n_pa_start - pa0, 255);
`endif

    // Asynchronous reset while a doubling is outstanding.
    push_expect(SW'(5), CW'(13), CW'(2));
    @(negedge clk);
    scalar = SW'(5); px = CW'(13); py = CW'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(pa_dbl && !pa_start) && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("wait_dbl_reached", pa_dbl && !pa_start, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_pa_dbl", pa_dbl, 0);
    check_eq("arst_x", x, 0);
    check_eq("arst_pa_x1", x1, 0);
    check_eq("arst_pa_x2", x2, 0);
    exp_ops.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Recovery: k=3 runs INIT, DBL, ADD.
    pa0 = n_pa_start;
    run_k(SW'(3), CW'(5), CW'(8), 1'b0, cyc);
`ifdef SCALAR_MULT_CONST_TIME_EN
    check_eq("k3_pa_count", n_pa_start - pa0, 3);
    run_k(SW'(4), CW'(3), CW'(1), 1'b0, cyc4);
    run_k(SW'(7), CW'(3), CW'(1), 1'b0, cyc7);
    check_eq("ct_k4_vs_k7_cycles", cyc4, cyc7);
`else
    check_eq("k3_pa_count", n_pa_start - pa0, 3);
    run_k(SW'(6), CW'(21), CW'(10), 1'b0, cyc);
`endif
    repeat (5) @(negedge clk);
    #1;
    check_eq("ops_drained", exp_ops.size(), 0);
    check_eq("results_drained", exp_res.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
